// File: rtl/mem_stage_ctrl_if.sv
// Memory-controller bus of the MEM stage: registered req/ack handshake,
// write data, read data and the watchdog error pulse.
interface mem_stage_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_err,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_err,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage: posted-write buffer, ordered read FSM, MEMWB register.
// Optional ack watchdog built in when MEM_TIMEOUT_EN is defined.
module mem_stage_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_W       = 5,
    parameter int WBUF_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              RegWrite_in,
    input  logic              MemToReg_in,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemSrc,
    input  logic              call_in,
    input  logic              ret_in,
    input  logic [REG_W-1:0]  DestReg_in,
    input  logic [ADDR_W-1:0] ALU_addr,
    input  logic [ADDR_W-1:0] NON_ALU_addr,
    input  logic [DATA_W-1:0] MemWrite_data,
    output logic              stall_out,
    output logic              valid_out,
    output logic              RegWrite_out,
    output logic              MemToReg_out,
    output logic              ret_out,
    output logic [REG_W-1:0]  DestReg_out,
    output logic [ADDR_W-1:0] ALU_result_out,
    output logic [DATA_W-1:0] MemRead_data,
    mem_stage_ctrl_if.master  bus
);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RDDRN = 2'd1;
    localparam logic [1:0] S_RDREQ = 2'd2;

    localparam logic [31:0] DEAD_WORD = 32'hDEADBEEF;
    localparam logic [DATA_W-1:0] DEAD_DATA = DATA_W'(DEAD_WORD);

    logic              is_wr, is_rd, full, done, deq;
    logic              rd_done, wr_stall, rd_stall, enq, fire, tmo;
    logic [ADDR_W-1:0] acc_addr;

    logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
    logic [ADDR_W-1:0] wb_addr_d [WBUF_DEPTH];
    logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];
    logic [DATA_W-1:0] wb_data_d [WBUF_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              valid_q, valid_d;
    logic              regwr_q, regwr_d;
    logic              m2r_q, m2r_d;
    logic              ret_q, ret_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic [ADDR_W-1:0] alu_q, alu_d;

    // A call is a push (write) and always beats a simultaneous ret.
    always_comb begin
        is_wr    = valid_in & (MemWrite | call_in);
        is_rd    = valid_in & (MemRead | ret_in) & ~is_wr;
        acc_addr = (MemSrc | call_in) ? NON_ALU_addr : ALU_addr;
    end

    assign full      = (cnt_q == CW'(WBUF_DEPTH));
    assign done      = req_q & (bus.mem_ack | tmo);
    assign deq       = done & we_q;
    assign rd_done   = done & ~we_q;
    assign wr_stall  = is_wr & full & ~deq;
    assign rd_stall  = is_rd & ~rd_done;
    assign stall_out = wr_stall | rd_stall;
    assign enq       = is_wr & ~wr_stall;
    assign fire      = valid_in & ~stall_out;

    always_comb begin
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (enq) begin
            wb_addr_d[wr_ptr_q] = acc_addr;
            wb_data_d[wr_ptr_q] = MemWrite_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
        if (enq & ~deq) cnt_d = cnt_q + 1'b1;
        if (~enq & deq) cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q & ~done;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (1'b1)
            state_q == S_IDLE: begin
                if (is_rd)
                    state_d = (cnt_q == '0) ? S_RDREQ : S_RDDRN;
            end
            state_q == S_RDDRN: begin
                if (cnt_q == '0) state_d = S_RDREQ;
            end
            state_q == S_RDREQ: begin
                if (rd_done) begin
                    state_d = S_IDLE;
                    rdata_d = tmo ? DEAD_DATA : bus.mem_rdata;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Buffered writes always reach memory before the read goes out.
        if (state_d == S_RDREQ && state_q != S_RDREQ) begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            maddr_d = acc_addr;
            wdata_d = '0;
        end else if (state_q != S_RDREQ && !req_q && cnt_q != '0) begin
            req_d   = 1'b1;
            we_d    = 1'b1;
            maddr_d = wb_addr_q[rd_ptr_q];
            wdata_d = wb_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        valid_d = fire;
        regwr_d = regwr_q;
        m2r_d   = m2r_q;
        ret_d   = ret_q;
        dest_d  = dest_q;
        alu_d   = alu_q;
        if (fire) begin
            regwr_d = RegWrite_in;
            m2r_d   = MemToReg_in;
            ret_d   = ret_in;
            dest_d  = DestReg_in;
            alu_d   = ALU_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_addr_q <= '{default: '0};
            wb_data_q <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            maddr_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
            regwr_q   <= 1'b0;
            m2r_q     <= 1'b0;
            ret_q     <= 1'b0;
            dest_q    <= '0;
            alu_q     <= '0;
        end else begin
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            maddr_q   <= maddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
            regwr_q   <= regwr_d;
            m2r_q     <= m2r_d;
            ret_q     <= ret_d;
            dest_q    <= dest_d;
            alu_q     <= alu_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;

    // Counter sits at zero whenever no request is outstanding.
    always_comb begin
        tmo = req_q & ~bus.mem_ack
            & (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
        tmo_cnt_d = '0;
        if (req_q & ~bus.mem_ack & ~tmo)
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        err_d = tmo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.mem_err = err_q;
`else
    assign tmo         = 1'b0;
    assign bus.mem_err = 1'b0;

    // The watchdog limit has no effect without the watchdog.
    if (TIMEOUT_CYC < 1) begin : g_tmo_unused
    end
`endif

    assign bus.mem_req    = req_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_wdata  = wdata_q;
    assign valid_out      = valid_q;
    assign RegWrite_out   = regwr_q;
    assign MemToReg_out   = m2r_q;
    assign ret_out        = ret_q;
    assign DestReg_out    = dest_q;
    assign ALU_result_out = alu_q;
    assign MemRead_data   = rdata_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus
// random instruction mix against a program-order memory model.
module tb_mem_stage_ctrl;
    logic        clk;
    logic        rst_n;
    logic        valid_in, RegWrite_in, MemToReg_in, MemRead, MemWrite;
    logic        MemSrc, call_in, ret_in;
    logic [4:0]  DestReg_in;
    logic [31:0] ALU_addr, NON_ALU_addr, MemWrite_data;
    logic        stall_out, valid_out, RegWrite_out, MemToReg_out, ret_out;
    logic [4:0]  DestReg_out;
    logic [31:0] ALU_result_out, MemRead_data;

    mem_stage_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_stage_ctrl #(
        .DATA_W(32), .ADDR_W(32), .REG_W(5),
        .WBUF_DEPTH(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .RegWrite_in(RegWrite_in),
        .MemToReg_in(MemToReg_in), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemSrc(MemSrc),
        .call_in(call_in), .ret_in(ret_in),
        .DestReg_in(DestReg_in), .ALU_addr(ALU_addr),
        .NON_ALU_addr(NON_ALU_addr), .MemWrite_data(MemWrite_data),
        .stall_out(stall_out), .valid_out(valid_out),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
        .ret_out(ret_out), .DestReg_out(DestReg_out),
        .ALU_result_out(ALU_result_out), .MemRead_data(MemRead_data),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit mr, mw, ms, call, ret, rw, m2r;
        logic [4:0]  dest;
        logic [31:0] alu, non, wd;
    } ins_t;

    typedef struct {
        logic [31:0] ctl, alu, data;
        bit rd, lat;
    } ret_t;

    typedef struct {
        logic [31:0] a, d;
    } wr_t;

    ret_t rq[$];
    wr_t  wq[$];
    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] ref_m [logic [31:0]];

    int total, bad, cyc;
    int ack_delay, age;
    bit force_ack;
    int rd_reqs, wr_acks, rd_ack_cyc, err_cnt;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] peek(bit use_ref, logic [31:0] a);
        if (use_ref) return ref_m.exists(a) ? ref_m[a] : (a ^ 32'h5A5A5A5A);
        return mem_m.exists(a) ? mem_m[a] : (a ^ 32'h5A5A5A5A);
    endfunction

    function automatic ins_t mk(bit mr, bit mw, bit ms, bit call, bit ret,
                                logic [31:0] alu, logic [31:0] non,
                                logic [31:0] wd);
        ins_t i;
        i.mr = mr; i.mw = mw; i.ms = ms; i.call = call; i.ret = ret;
        i.rw = 1'($urandom_range(0, 1));
        i.m2r = 1'($urandom_range(0, 1));
        i.dest = 5'($urandom_range(0, 31));
        i.alu = alu; i.non = non; i.wd = wd;
        return i;
    endfunction

    // One clock: memory responder, handshake and retire checks.
    task automatic clk_cycle(output bit st);
        bit ack, req_now, we_now;
        logic [31:0] addr_now, wd_now;
        ret_t r;
        wr_t w;
        req_now  = bus.mem_req;
        we_now   = bus.mem_we;
        addr_now = bus.mem_addr;
        wd_now   = bus.mem_wdata;
        ack = req_now && (force_ack || (ack_delay >= 0 && age >= ack_delay));
        bus.mem_ack = ack;
        bus.mem_rdata = (ack && !we_now) ? peek(0, addr_now) : $urandom;
        @(negedge clk);
        st = stall_out;
        @(posedge clk);
        #1;
        cyc++;
        if (ack && we_now) begin
            wr_acks++;
            chk("wr_expected", 32'(wq.size() != 0), 1);
            if (wq.size() != 0) begin
                w = wq.pop_front();
                chk("wr_addr", addr_now, w.a);
                chk("wr_data", wd_now, w.d);
            end
            mem_m[addr_now] = wd_now;
        end
        if (ack && !we_now) rd_ack_cyc = cyc;
        if (req_now && !ack && !bus.mem_err) begin
            chk("req_hold", 32'(bus.mem_req), 1);
            chk("we_hold", 32'(bus.mem_we), 32'(we_now));
            chk("addr_hold", bus.mem_addr, addr_now);
        end
        if (bus.mem_req && !bus.mem_we && (!req_now || ack)) begin
            rd_reqs++;
            chk("rd_after_wr", wq.size(), 0);
        end
        age = (bus.mem_req && req_now && !ack) ? age + 1 : 0;
        if (bus.mem_err) err_cnt++;
        if (valid_out) begin
            chk("retire_expected", 32'(rq.size() != 0), 1);
            if (rq.size() != 0) begin
                r = rq.pop_front();
                chk("ctl", 32'({RegWrite_out, MemToReg_out, ret_out,
                                DestReg_out}), r.ctl);
                chk("alu_out", ALU_result_out, r.alu);
                if (r.rd) chk("rd_data", MemRead_data, r.data);
                if (r.rd && r.lat) chk("rd_latency", rd_ack_cyc, cyc);
            end
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic idle(int n);
        bit st;
        valid_in = 1'b0;
        repeat (n) clk_cycle(st);
    endtask

    // Reference decode and expected outcome of one instruction.
    task automatic start(ins_t i, bit to_rd);
        bit wr, rd;
        logic [31:0] a;
        ret_t r;
        wr = i.mw | i.call;
        rd = !wr && (i.mr | i.ret);
        a  = (i.ms | i.call) ? i.non : i.alu;
        r.ctl  = 32'({i.rw, i.m2r, i.ret, i.dest});
        r.alu  = i.alu;
        r.rd   = rd;
        r.lat  = !to_rd;
        r.data = to_rd ? 32'hDEADBEEF : peek(1, a);
        rq.push_back(r);
        if (wr) begin
            wq.push_back('{a: a, d: i.wd});
            ref_m[a] = i.wd;
        end
        valid_in = 1'b1;
        RegWrite_in = i.rw; MemToReg_in = i.m2r;
        MemRead = i.mr; MemWrite = i.mw; MemSrc = i.ms;
        call_in = i.call; ret_in = i.ret;
        DestReg_in = i.dest; ALU_addr = i.alu;
        NON_ALU_addr = i.non; MemWrite_data = i.wd;
    endtask

    task automatic finish_accept(inout int n);
        bit st;
        st = 1'b1;
        for (int k = 0; k < 64 && st; k++) begin
            clk_cycle(st);
            n++;
        end
        if (st) chk("accept_bound", 32'(st), 0);
        valid_in = 1'b0;
    endtask

    task automatic send(ins_t i, bit to_rd, output int n);
        n = 0;
        start(i, to_rd);
        finish_accept(n);
    endtask

    initial begin
        ins_t i;
        bit st;
        int n, r0, w0, e0, op;
        total = 0; bad = 0; cyc = 0;
        ack_delay = -1; age = 0; force_ack = 1'b0;
        rd_reqs = 0; wr_acks = 0; rd_ack_cyc = -1; err_cnt = 0;
        valid_in = 0; RegWrite_in = 0; MemToReg_in = 0;
        MemRead = 0; MemWrite = 0; MemSrc = 0;
        call_in = 0; ret_in = 0; DestReg_in = 0;
        ALU_addr = 0; NON_ALU_addr = 0; MemWrite_data = 0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_req", 32'(bus.mem_req), 0);
        chk("rst_stall", 32'(stall_out), 0);
        chk("rst_rdata", MemRead_data, 0);
        chk("rst_err", 32'(bus.mem_err), 0);
        chk("rst_dest", 32'(DestReg_out), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a read waiting behind a buffered store.
        send(mk(0, 1, 0, 0, 0, 32'h40, 0, 32'h1234), 0, n);
        start(mk(1, 0, 0, 0, 0, 32'h44, 0, 0), 0);
        repeat (3) clk_cycle(st);
        chk("t1_stalled", 32'(st), 1);
        chk("t1_req_before", 32'(bus.mem_req), 1);
        #2;
        rst_n = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("t1_req_drop", 32'(bus.mem_req), 0);
        chk("t1_valid_zero", 32'(valid_out), 0);
        chk("t1_rdata_zero", MemRead_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rq.delete();
        wq.delete();
        ref_m = mem_m;
        age = 0;
        for (int k = 0; k < 5; k++) begin
            clk_cycle(st);
            chk("t1_empty", 32'(bus.mem_req), 0);
        end

        // Single posted store acked late.
        ack_delay = 3;
        w0 = wr_acks;
        r0 = rd_reqs;
        send(mk(0, 1, 0, 0, 0, 32'h10, 0, 32'hAA), 0, n);
        chk("t2_no_stall", n, 1);
        idle(10);
        chk("t2_one_write", wr_acks - w0, 1);
        chk("t2_no_read", rd_reqs - r0, 0);

        // Fill the buffer with memory silent, then free a slot by ack.
        ack_delay = -1;
        for (int k = 0; k < 4; k++) begin
            send(mk(0, 1, 0, 0, 0, 32'h80 + 32'(k * 4), 0,
                    32'hC0 + 32'(k)), 0, n);
            chk("t3_accept", n, 1);
        end
        start(mk(0, 1, 0, 0, 0, 32'h90, 0, 32'hC4), 0);
        clk_cycle(st);
        chk("t3_full_stall", 32'(st), 1);
        force_ack = 1'b1;
        clk_cycle(st);
        chk("t3_ack_accept", 32'(st), 0);
        force_ack = 1'b0;
        valid_in = 1'b0;
        start(mk(0, 1, 0, 0, 0, 32'h94, 0, 32'hC5), 0);
        clk_cycle(st);
        chk("t3_still_full", 32'(st), 1);
        ack_delay = 2;
        n = 0;
        finish_accept(n);
        idle(30);

        // Load right behind a store to the same address.
        ack_delay = 2;
        send(mk(0, 1, 0, 0, 0, 32'h20, 0, 32'h55), 0, n);
        send(mk(1, 0, 0, 0, 0, 32'h20, 0, 0), 0, n);
        idle(2);
        chk("t4_rdata", MemRead_data, 32'h55);

        // call and ret together: one push, no pop.
        w0 = wr_acks;
        r0 = rd_reqs;
        send(mk(0, 0, 0, 1, 1, 32'h700, 32'h3FC, 32'hBEEF), 0, n);
        idle(10);
        chk("t5_one_write", wr_acks - w0, 1);
        chk("t5_no_read", rd_reqs - r0, 0);
        chk("t5_mem", peek(0, 32'h3FC), 32'hBEEF);

        // Random mix against the program-order model.
        for (int k = 0; k < 160; k++) begin
            op = $urandom_range(0, 6);
            i = mk(op == 1 || op == 6, op == 2 || op == 6,
                   1'($urandom_range(0, 1)),
                   op == 3 || op == 5, op == 4 || op == 5,
                   32'h100 + 32'($urandom_range(0, 7)) * 4,
                   32'h3F0 + 32'($urandom_range(0, 3)) * 4,
                   $urandom);
            ack_delay = $urandom_range(0, 4);
            send(i, 0, n);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        ack_delay = 1;
        idle(40);

`ifdef MEM_TIMEOUT_EN
        // Read never acked: watchdog completes it.
        ack_delay = -1;
        e0 = err_cnt;
        send(mk(1, 0, 0, 0, 0, 32'h200, 0, 0), 1, n);
        chk("t6_stall_len", n, 9);
        idle(4);
        chk("t6_err_once", err_cnt - e0, 1);
        chk("t6_rdata", MemRead_data, 32'hDEADBEEF);
        ack_delay = 1;
`else
        e0 = 0;
        chk("no_err", err_cnt, e0);
`endif

        chk("final_wq", wq.size(), 0);
        chk("final_rq", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
